// File: rtl/avalon_job_master.sv
// Avalon-MM job fetcher: reads a header/target descriptor one word at a time,
// hands it to the miner core, then writes back the nonce and a status word.
module avalon_job_master #(
  parameter int unsigned ADDRESSWIDTH = 26,
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned HDR_WORDS    = 20,
  parameter int unsigned TGT_WORDS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [DATAWIDTH-1:0]    master_writedata,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest,
  output logic [HDR_WORDS*32-1:0] hdr_words,
  output logic [TGT_WORDS*32-1:0] target,
  output logic                    job_valid,
  input  logic                    result_valid,
  input  logic                    result_found,
  input  logic [31:0]             result_nonce,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned TOTAL = HDR_WORDS + TGT_WORDS;
  localparam int unsigned IW    = $clog2(TOTAL + 1);
  localparam logic [ADDRESSWIDTH-1:0] NONCE_OFF  = ADDRESSWIDTH'(4 * TOTAL);
  localparam logic [ADDRESSWIDTH-1:0] STATUS_OFF = ADDRESSWIDTH'(4 * TOTAL + 4);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, JOB, WR_NONCE, WR_STATUS, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] base_q, base_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [HDR_WORDS*32-1:0] hdr_q, hdr_d;
  logic [TGT_WORDS*32-1:0] tgt_q, tgt_d;
  logic [31:0]             nonce_q, nonce_d;
  logic                    found_q, found_d;
  logic                    job_valid_q, job_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      hdr_q       <= '0;
      tgt_q       <= '0;
      nonce_q     <= '0;
      found_q     <= 1'b0;
      job_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      hdr_q       <= hdr_d;
      tgt_q       <= tgt_d;
      nonce_q     <= nonce_d;
      found_q     <= found_d;
      job_valid_q <= job_valid_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    idx_d            = idx_q;
    hdr_d            = hdr_q;
    tgt_d            = tgt_q;
    nonce_d          = nonce_q;
    found_d          = found_q;
    job_valid_d      = 1'b0;
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr & ~ADDRESSWIDTH'(3);
          idx_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        master_read    = 1'b1;
        master_address = base_q + (ADDRESSWIDTH'(idx_q) << 2);
        if (!master_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (master_readdatavalid) begin
          // Word index selects header slot first, then target slot.
          for (int unsigned i = 0; i < HDR_WORDS; i++)
            if (idx_q == IW'(i)) hdr_d[32*i +: 32] = 32'(master_readdata);
          for (int unsigned j = 0; j < TGT_WORDS; j++)
            if (idx_q == IW'(HDR_WORDS + j)) tgt_d[32*j +: 32] = 32'(master_readdata);
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(TOTAL - 1)) begin
            state_d     = JOB;
            job_valid_d = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      JOB: begin
        if (result_valid) begin
          nonce_d = result_nonce;
          found_d = result_found;
          state_d = WR_NONCE;
        end
      end
      WR_NONCE: begin
        master_write     = 1'b1;
        master_address   = base_q + NONCE_OFF;
        master_writedata = DATAWIDTH'(nonce_q);
        if (!master_waitrequest) state_d = WR_STATUS;
      end
      WR_STATUS: begin
        master_write     = 1'b1;
        master_address   = base_q + STATUS_OFF;
        master_writedata = DATAWIDTH'({30'b0, 1'b1, found_q});
        if (!master_waitrequest) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hdr_words = hdr_q;
  assign target    = tgt_q;
  assign job_valid = job_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_avalon_job_master.sv
// Bench for avalon_job_master: Avalon slave model with configurable stall and
// read latency, descriptor reference model, directed and random jobs.
module tb_avalon_job_master;

  localparam int unsigned AW    = 26;
  localparam int unsigned DW    = 32;
  localparam int unsigned HW    = 20;
  localparam int unsigned TW    = 8;
  localparam int unsigned TOTAL = HW + TW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] master_address;
  logic          master_read;
  logic          master_write;
  logic [DW-1:0] master_writedata;
  logic [DW-1:0] master_readdata;
  logic          master_readdatavalid;
  logic          master_waitrequest;
  logic [HW*32-1:0] hdr_words;
  logic [TW*32-1:0] target;
  logic          job_valid;
  logic          result_valid;
  logic          result_found;
  logic [31:0]   result_nonce;
  logic          busy;
  logic          done;

  avalon_job_master #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .HDR_WORDS(HW), .TGT_WORDS(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_writedata(master_writedata),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest), .hdr_words(hdr_words),
    .target(target), .job_valid(job_valid), .result_valid(result_valid),
    .result_found(result_found), .result_nonce(result_nonce),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          wait_n = 0;
  int          lat    = 1;
  logic [31:0] salt   = '0;
  logic [AW-1:0] cur_base = '0;
  bit          stray_req = 1'b0;
  int          jv_cnt = 0;
  int          done_cnt = 0;
  bit          done_at_accept = 1'b0;

  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [31:0]   wr_data_log[$];

  // Memory content: word k of the descriptor is 0xA0000000+k, optionally scrambled.
  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - cur_base;
    return salt ^ (32'hA000_0000 + 32'(off >> 2));
  endfunction

  // Avalon slave: stalls each request wait_n cycles, returns read data lat cycles after accept.
  initial begin : slave
    bit            acc_pend, acc_rd, stalling;
    logic [AW-1:0] acc_addr, hold_addr, pend_addr;
    logic [31:0]   acc_data, hold_data;
    bit            hold_rd;
    int            stall, cnt, outstanding;
    acc_pend = 0; acc_rd = 0; stalling = 0; hold_rd = 0;
    acc_addr = '0; hold_addr = '0; pend_addr = '0; acc_data = '0; hold_data = '0;
    stall = 0; cnt = 0; outstanding = 0;
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        acc_pend = 0; stall = 0; stalling = 0; outstanding = 0;
      end
      if (job_valid) jv_cnt++;
      if (done) begin
        done_cnt++;
        done_at_accept = acc_pend && !acc_rd;
      end
      if (acc_pend) begin
        if (acc_rd) begin
          checks++;
          if (outstanding != 0) begin
            errors++;
            $display("FAIL one_outstanding: got %0d outstanding required 0 at addr %h", outstanding, acc_addr);
          end
          outstanding++;
          rd_log.push_back(acc_addr);
          pend_addr = acc_addr;
          cnt = lat;
        end else begin
          wr_addr_log.push_back(acc_addr);
          wr_data_log.push_back(acc_data);
        end
        acc_pend = 0;
      end
      master_readdatavalid = 1'b0;
      master_readdata = $urandom;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = data_of(pend_addr);
          if (outstanding > 0) outstanding--;
        end
      end else if (stray_req) begin
        master_readdatavalid = 1'b1;
        stray_req = 1'b0;
      end
      if (master_read || master_write) begin
        checks++;
        if (master_read && master_write) begin
          errors++;
          $display("FAIL rd_wr_exclusive: got read=%b write=%b required not both", master_read, master_write);
        end
        if (stalling) begin
          checks++;
          if (master_address !== hold_addr || master_read !== hold_rd || master_writedata !== hold_data) begin
            errors++;
            $display("FAIL stall_stable: got addr %h rd %b wd %h required addr %h rd %b wd %h",
                     master_address, master_read, master_writedata, hold_addr, hold_rd, hold_data);
          end
        end
        if (stall < wait_n) begin
          master_waitrequest = 1'b1;
          stall++;
          stalling = 1;
          hold_addr = master_address; hold_rd = master_read; hold_data = master_writedata;
        end else begin
          master_waitrequest = 1'b0;
          stall = 0;
          stalling = 0;
          acc_pend = 1; acc_rd = master_read;
          acc_addr = master_address; acc_data = master_writedata;
        end
      end else begin
        checks++;
        if (stalling) begin
          errors++;
          $display("FAIL request_dropped: got no request required held addr %h", hold_addr);
        end
        master_waitrequest = 1'b0;
        stall = 0;
        stalling = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({master_read, master_write, job_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rd%b wr%b jv%b busy%b done%b required all 0",
               master_read, master_write, job_valid, busy, done);
    end
    checks++;
    if (master_address !== '0 || master_writedata !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr %h wd %h required 0 0", master_address, master_writedata);
    end
    checks++;
    if (hdr_words !== '0 || target !== '0) begin
      errors++;
      $display("FAIL reset_buffers: got hdr0 %h tgt0 %h required 0", hdr_words[31:0], target[31:0]);
    end
  endtask

  // One full job: fetch, verify against the descriptor model, report a result, verify writeback.
  task automatic run_job(input logic [AW-1:0] base, input int wn, input int lt,
                         input logic fnd, input logic [31:0] nonce, input logic inject,
                         input logic [31:0] slt, input string tag);
    int n;
    logic [AW-1:0] a;
    logic [31:0] exp_w;
    logic [HW*32-1:0] hdr_snap;
    logic [TW*32-1:0] tgt_snap;
    wait_n = wn; lat = lt; salt = slt; cur_base = base & ~AW'(3);
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    jv_cnt = 0; done_cnt = 0; done_at_accept = 0;
    @(negedge clk);
    base_addr = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0; base_addr = AW'($urandom);
    n = 0;
    while (job_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (job_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s job_valid_timeout: got %b required 1", tag, job_valid);
    end
    hdr_snap = hdr_words; tgt_snap = target;
    checks++;
    if (rd_log.size() != TOTAL) begin
      errors++;
      $display("FAIL %s read_count: got %0d required %0d", tag, rd_log.size(), TOTAL);
    end
    for (int k = 0; k < TOTAL && k < rd_log.size(); k++) begin
      a = cur_base + AW'(4 * k);
      checks++;
      if (rd_log[k] !== a) begin
        errors++;
        $display("FAIL %s read_addr[%0d]: got %h required %h", tag, k, rd_log[k], a);
      end
    end
    @(negedge clk);
    checks++;
    if (job_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s job_valid_width: got %b required 0", tag, job_valid);
    end
    start = inject;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    result_valid = 1'b1; result_found = fnd; result_nonce = nonce;
    @(negedge clk);
    result_valid = 1'b0; result_found = ~fnd; result_nonce = $urandom;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); start = inject; n++; end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: got %b required 1", tag, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done %b busy %b required 0 0", tag, done, busy);
    end
    checks++;
    if (done_cnt != 1 || jv_cnt != 1 || !done_at_accept) begin
      errors++;
      $display("FAIL %s pulses: got done %0d jv %0d done_after_accept %0d required 1 1 1",
               tag, done_cnt, jv_cnt, done_at_accept);
    end
    checks++;
    if (wr_addr_log.size() != 2) begin
      errors++;
      $display("FAIL %s write_count: got %0d required 2", tag, wr_addr_log.size());
    end else begin
      a = cur_base + AW'(4 * TOTAL);
      checks++;
      if (wr_addr_log[0] !== a || wr_data_log[0] !== nonce) begin
        errors++;
        $display("FAIL %s nonce_write: got %h/%h required %h/%h", tag, wr_addr_log[0], wr_data_log[0], a, nonce);
      end
      a = cur_base + AW'(4 * TOTAL + 4);
      exp_w = {30'b0, 1'b1, fnd};
      checks++;
      if (wr_addr_log[1] !== a || wr_data_log[1] !== exp_w) begin
        errors++;
        $display("FAIL %s status_write: got %h/%h required %h/%h", tag, wr_addr_log[1], wr_data_log[1], a, exp_w);
      end
    end
    checks++;
    if (hdr_words !== hdr_snap || target !== tgt_snap) begin
      errors++;
      $display("FAIL %s buffers_stable: got hdr0 %h tgt0 %h required %h %h",
               tag, hdr_words[31:0], target[31:0], hdr_snap[31:0], tgt_snap[31:0]);
    end
    for (int k = 0; k < TOTAL; k++) begin
      exp_w = data_of(cur_base + AW'(4 * k));
      checks++;
      if (k < HW) begin
        if (hdr_words[32*k +: 32] !== exp_w) begin
          errors++;
          $display("FAIL %s hdr[%0d]: got %h required %h", tag, k, hdr_words[32*k +: 32], exp_w);
        end
      end else if (target[32*(k-HW) +: 32] !== exp_w) begin
        errors++;
        $display("FAIL %s target[%0d]: got %h required %h", tag, k - HW, target[32*(k-HW) +: 32], exp_w);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_log.size() != TOTAL) begin
      errors++;
      $display("FAIL %s stays_idle: got busy %b reads %0d required 0 %0d", tag, busy, rd_log.size(), TOTAL);
    end
  endtask

  task automatic test_zero_wait();
    run_job(AW'('h100), 0, 1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, "zero_wait");
    checks++;
    if (hdr_words[31:0] !== 32'hA000_0000 || target[7*32 +: 32] !== 32'hA000_001B) begin
      errors++;
      $display("FAIL zero_wait_words: got %h %h required a0000000 a000001b", hdr_words[31:0], target[7*32 +: 32]);
    end
    checks++;
    if (rd_log.size() != TOTAL || rd_log[TOTAL-1] !== AW'('h16C)) begin
      errors++;
      $display("FAIL zero_wait_last_addr: got %0d reads required last at 16c", rd_log.size());
    end
    checks++;
    if (wr_data_log.size() != 2 || wr_data_log[1] !== 32'h3) begin
      errors++;
      $display("FAIL found_status: got %0d writes required status 00000003", wr_data_log.size());
    end
  endtask

  task automatic test_stall();
    run_job(AW'('h100), 3, 2, 1'b1, 32'h1234_5678, 1'b0, 32'h0, "stall");
  endtask

  task automatic test_not_found_start_ignored();
    run_job(AW'('h100), 2, 1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0, "not_found");
    checks++;
    if (wr_data_log.size() != 2 || wr_data_log[1] !== 32'h2) begin
      errors++;
      $display("FAIL not_found_status: got %0d writes required status 00000002", wr_data_log.size());
    end
  endtask

  task automatic test_wrap();
    run_job(AW'('h3FF_FFF0), 1, 1, 1'b1, 32'hCAFE_0001, 1'b0, 32'h5A5A_0000, "wrap");
    checks++;
    if (rd_log.size() != TOTAL || rd_log[3] !== AW'('h3FF_FFFC) || rd_log[4] !== '0) begin
      errors++;
      $display("FAIL wrap_addr: got %0d reads required 3fffffc then 0000000", rd_log.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    wait_n = 0; lat = 4; salt = 32'h0; cur_base = AW'('h200);
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    @(negedge clk);
    base_addr = AW'('h200); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rd_log.size() < 6 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (rd_log.size() != 6) begin
      errors++;
      $display("FAIL reset_mid_reach: got %0d reads required 6", rd_log.size());
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    stray_req = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({master_read, master_write, job_valid, busy, done} !== 5'b0 ||
        master_address !== '0 || master_writedata !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got rd%b wr%b jv%b busy%b done%b addr %h required all 0",
               master_read, master_write, job_valid, busy, done, master_address);
    end
    checks++;
    if (hdr_words !== '0 || target !== '0) begin
      errors++;
      $display("FAIL reset_mid_buffers: got hdr0 %h hdr5 %h required 0", hdr_words[31:0], hdr_words[5*32 +: 32]);
    end
    checks++;
    if (rd_log.size() != 6) begin
      errors++;
      $display("FAIL reset_mid_no_reads: got %0d reads required 6", rd_log.size());
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_job(AW'($urandom), $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom),
              $urandom, 1'($urandom), $urandom, "random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0;
    result_valid = 1'b0; result_found = 1'b0; result_nonce = '0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_not_found_start_ignored();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
